// File: rtl/mdu_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
// Holds the opcode and FSM state encodings.
package mdu_pkg;

  localparam int MduWidth  = 32;
  localparam int MduCycles = 32;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between EX operand logic and the mul/div unit.
// The unit side is the slave; the pipeline side drives requests.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int Width = MduWidth
);

  logic             start_i;
  logic [2:0]       op_i;
  logic [Width-1:0] a_i;
  logic [Width-1:0] b_i;
  logic             cancel_i;
  logic             busy_o;
  logic             done_o;
  logic [Width-1:0] hi_o;
  logic [Width-1:0] lo_o;

  modport master (
    output start_i,
    output op_i,
    output a_i,
    output b_i,
    output cancel_i,
    input  busy_o,
    input  done_o,
    input  hi_o,
    input  lo_o
  );

  modport slave (
    input  start_i,
    input  op_i,
    input  a_i,
    input  b_i,
    input  cancel_i,
    output busy_o,
    output done_o,
    output hi_o,
    output lo_o
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Final sign correction of the magnitude result pair.
// Full-pair negate for products, per-half negate for quotient/remainder.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int Width = MduWidth
) (
  input  logic [2*Width-1:0] pair,
  input  logic               neg_pair,
  input  logic               neg_hi,
  input  logic               neg_lo,
  output logic [Width-1:0]   hi,
  output logic [Width-1:0]   lo
);

  logic [2*Width-1:0] full;

  // negate the whole product, then each half independently for divides
  always_comb begin
    full = neg_pair ? -pair : pair;
    hi = full[2*Width-1:Width];
    lo = full[Width-1:0];
    if (neg_hi) hi = -full[2*Width-1:Width];
    if (neg_lo) lo = -full[Width-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO, one result bit per cycle.
// Signed ops run on magnitudes; signs are restored on the final step.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int Width  = MduWidth,
  parameter int Cycles = MduCycles
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_div_unit_if.slave bus
);

  localparam int CntW = $clog2(Cycles);
  localparam logic [CntW-1:0] CntLast =
    CntW'(Cycles - 1);

  mdu_state_t       state;
  logic [CntW-1:0]  cnt;
  logic             busy;
  logic             done;
  logic [Width-1:0] hi;
  logic [Width-1:0] lo;

  // hi half carries a spare bit: product carry / divide trial sign
  logic [Width:0]   acc_hi;
  logic [Width-1:0] acc_lo;
  logic [Width-1:0] opnd;
  logic             mul_mode;
  logic             neg_pair;
  logic             neg_hi;
  logic             neg_lo;

  logic             accept;
  logic             is_mul;
  logic             is_signed;
  logic             is_mthi;
  logic             is_mtlo;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [Width-1:0] mag_a;
  logic [Width-1:0] mag_b;

  logic [Width:0]     addend;
  logic [Width:0]     sum;
  logic [Width:0]     shifted;
  logic [Width:0]     trial;
  logic [Width:0]     nxt_hi;
  logic [Width-1:0]   nxt_lo;
  logic [2*Width-1:0] pair;
  logic [Width-1:0]   fix_hi;
  logic [Width-1:0]   fix_lo;

  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.hi_o   = hi;
  assign bus.lo_o   = lo;

  assign accept = bus.start_i & ~bus.cancel_i
                & ~busy & (bus.op_i <= 3'd5);

  assign is_mul    = (bus.op_i == MULT)
                   | (bus.op_i == MULTU);
  assign is_signed = (bus.op_i == MULT)
                   | (bus.op_i == DIV);
  assign is_mthi   = (bus.op_i == MTHI);
  assign is_mtlo   = (bus.op_i == MTLO);

  assign a_neg  = is_signed & bus.a_i[Width-1];
  assign b_neg  = is_signed & bus.b_i[Width-1];
  assign b_zero = (bus.b_i == '0);
  assign mag_a  = a_neg ? -bus.a_i : bus.a_i;
  assign mag_b  = b_neg ? -bus.b_i : bus.b_i;

  // one shift-add or restoring shift-subtract step
  always_comb begin
    addend  = acc_lo[0] ? {1'b0, opnd} : '0;
    sum     = acc_hi + addend;
    shifted = {acc_hi[Width-1:0], acc_lo[Width-1]};
    trial   = shifted - {1'b0, opnd};
    if (mul_mode) begin
      nxt_hi = {1'b0, sum[Width:1]};
      nxt_lo = {sum[0], acc_lo[Width-1:1]};
    end else begin
      nxt_hi = trial[Width] ? shifted : trial;
      nxt_lo = {acc_lo[Width-2:0], ~trial[Width]};
    end
    pair = {nxt_hi[Width-1:0], nxt_lo};
  end

  mdu_sign_fix #(
    .Width(Width)
  ) u_sign_fix (
    .pair    (pair),
    .neg_pair(neg_pair),
    .neg_hi  (neg_hi),
    .neg_lo  (neg_lo),
    .hi      (fix_hi),
    .lo      (fix_lo)
  );

  // control FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      mul_mode <= 1'b0;
      neg_pair <= 1'b0;
      neg_hi   <= 1'b0;
      neg_lo   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          if (bus.cancel_i) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            if (cnt == '0) begin
              hi    <= fix_hi;
              lo    <= fix_lo;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            unique case (1'b1)
              is_mthi: hi <= bus.a_i;
              is_mtlo: lo <= bus.a_i;
              default: begin
                state    <= RUN;
                busy     <= 1'b1;
                cnt      <= CntLast;
                acc_hi   <= '0;
                acc_lo   <= is_mul ? mag_b : mag_a;
                opnd     <= is_mul ? mag_a : mag_b;
                mul_mode <= is_mul;
                neg_pair <= is_mul & (a_neg ^ b_neg);
                neg_hi   <= ~is_mul & a_neg;
                neg_lo   <= ~is_mul & (a_neg ^ b_neg)
                          & ~b_zero;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
